// File: rtl/ddr_wr_burst_ctrl.sv
// ddr_wr_burst_ctrl: drains 256-bit capture FIFO words into DDR as AXI4 INCR write bursts
// One frame of FRAME_WORDS words is written contiguously from BASE_ADDR, one burst outstanding at a time.
// Ports: clk, rst (async, active high); start/busy/done/err frame control; fifo_rd_* FIFO read side;
//        m_aw*/m_w*/m_b* AXI4 write address, data and response channels.
// Optional macro DDR_WR_TIMEOUT_EN adds a watchdog that aborts the frame after TIMEOUT_CYC idle cycles.
module ddr_wr_burst_ctrl #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 28,
  parameter int BURST_LEN = 16,
  parameter int FRAME_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp
);
  localparam int NB = FRAME_WORDS / BURST_LEN;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int CW = $clog2(NB) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [CW-1:0] NB_C = CW'(NB);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  typedef enum logic [2:0] {IDLE, AW, W, B, FIN} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic err_q, err_d;
  logic aw_hs, w_hs, b_hs, last_beat, active, tmo;
  assign last_beat = beat_q == LAST_BEAT;
  assign active = state_q inside {AW, W, B};
`ifdef DDR_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
  // any handshake is progress and restarts the watchdog
  assign tmo_d = (active && !(aw_hs || w_hs || b_hs)) ? tmo_q + 1'b1 : '0;
  assign tmo = active && !(aw_hs || w_hs || b_hs) && (tmo_q == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYC[0];
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      burst_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = AW;
        err_d   = 1'b0;
        addr_d  = BASE_ADDR;
        beat_d  = '0;
        burst_d = '0;
      end
      AW: state_d = aw_hs ? W : AW;
      W: if (w_hs) begin
        beat_d  = last_beat ? '0 : beat_q + 1'b1;
        burst_d = last_beat ? burst_q + 1'b1 : burst_q;
        state_d = last_beat ? B : W;
      end
      B: if (b_hs) begin
        err_d   = err_q | (m_bresp != 2'b00);
        state_d = (burst_q == NB_C) ? FIN : AW;
        addr_d  = (burst_q == NB_C) ? addr_q : addr_q + BURST_BYTES;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = FIN;
      err_d   = 1'b1;
    end
  end
  always_comb begin
    busy       = active;
    done       = state_q == FIN;
    err        = err_q;
    m_awaddr   = addr_q;
    m_awlen    = 8'(BURST_LEN - 1);
    m_awvalid  = state_q == AW;
    m_wdata    = fifo_rd_data;
    m_wstrb    = '1;
    m_wvalid   = (state_q == W) && fifo_rd_vld;
    m_wlast    = (state_q == W) && last_beat;
    fifo_rd_en = m_wvalid && m_wready;
    m_bready   = state_q == B;
    aw_hs      = m_awvalid && m_awready;
    w_hs       = fifo_rd_en;
    b_hs       = m_bready && m_bvalid;
  end
endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb_ddr_wr_burst_ctrl: randomized frame writes checked against a queue-based AXI/FIFO reference model
module tb_ddr_wr_burst_ctrl;
  localparam int DW = 256;
  localparam int AW = 28;
  localparam int BL = 4;
  localparam int FW = 8;
  localparam int TO = 16;
  localparam int NB = FW / BL;
  localparam int BB = BL * DW / 8;
  localparam logic [AW-1:0] BASE = 28'h100;
  logic clk = 1'b0;
  logic rst, start, busy, done, err, fifo_rd_en, fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data, m_wdata;
  logic [AW-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW/8-1:0] m_wstrb;
  logic [1:0] m_bresp;
  ddr_wr_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW),
                      .BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [DW-1:0] fifo_q[$];
  logic [AW-1:0] aw_addrs[$];
  int aw_cnt, beats, b_cnt, b_owed, done_cnt;
  int aw_p, w_p, b_p, vld_p, gap_at, gap_left;
  bit w_tog, exp_aw_next, exp_done_next, prev_awv, prev_awhs;
  logic [AW-1:0] prev_addr;
  logic [1:0] bresp_plan[NB];
  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  // observe at negedge (what the next posedge will act on), then drive new inputs just after posedge
  task automatic step();
    @(negedge clk);
    if (exp_aw_next) chk("aw_after_b", m_awvalid, 1'b1);
    if (exp_done_next) chk("done_after_b", done, 1'b1);
    exp_aw_next = 0;
    exp_done_next = 0;
    if (prev_awv && !prev_awhs) begin
      chk("aw_hold", m_awvalid, 1'b1);
      chk("aw_addr_hold", m_awaddr, prev_addr);
    end
    chk("rd_en", fifo_rd_en, m_wvalid & m_wready);
    if (!fifo_rd_vld) chk("wvalid_gap", m_wvalid, 1'b0);
    if (done) chk("busy_at_done", busy, 1'b0);
    if (m_awvalid && m_awready) begin
      aw_addrs.push_back(m_awaddr);
      aw_cnt++;
    end
    if (m_wvalid && m_wready) begin
      chk("aw_first", (beats / BL) < aw_cnt, 1'b1);
      chk("wdata", m_wdata, fifo_q.size() > 0 ? fifo_q[0] : '0);
      chk("wlast", m_wlast, (beats % BL) == BL - 1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      beats++;
      if (beats % BL == 0) b_owed++;
    end
    if (m_bvalid && m_bready) begin
      b_cnt++;
      b_owed--;
      if (b_cnt == NB) exp_done_next = 1;
      else exp_aw_next = 1;
    end
    if (done) done_cnt++;
    prev_awv = m_awvalid;
    prev_awhs = m_awvalid && m_awready;
    prev_addr = m_awaddr;
    @(posedge clk);
    #1;
    m_awready = ($urandom() % 100) < aw_p;
    m_wready = w_tog ? ~m_wready : (($urandom() % 100) < w_p);
    fifo_rd_vld = fifo_q.size() > 0 && (($urandom() % 100) < vld_p);
    if (gap_left > 0 && beats == gap_at) begin
      fifo_rd_vld = 1'b0;
      gap_left--;
    end
    fifo_rd_data = fifo_q.size() > 0 ? fifo_q[0] : '0;
    m_bvalid = b_owed > 0 && (($urandom() % 100) < b_p);
    m_bresp = bresp_plan[b_cnt % NB];
  endtask
  task automatic knobs(input int a, input int w, input int b, input int v, input bit t);
    aw_p = a; w_p = w; b_p = b; vld_p = v; w_tog = t;
  endtask
  task automatic begin_frame(input logic [1:0] b0, input logic [1:0] b1);
    fifo_q.delete();
    aw_addrs.delete();
    for (int i = 0; i < FW; i++) fifo_q.push_back(rnd_word());
    aw_cnt = 0; beats = 0; b_cnt = 0; b_owed = 0; done_cnt = 0;
    prev_awv = 0; exp_aw_next = 0; exp_done_next = 0;
    bresp_plan[0] = b0;
    bresp_plan[1] = b1;
    fifo_rd_data = fifo_q[0];
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_awvalid", m_awvalid, 1'b1);
    chk("start_addr", m_awaddr, BASE);
    chk("start_busy", busy, 1'b1);
    chk("start_err_clr", err, 1'b0);
  endtask
  task automatic end_frame(input logic exp_err);
    int n = 0;
    while (done_cnt == 0 && n < 1000) begin
      step();
      n++;
    end
    chk("done_seen", done_cnt > 0, 1'b1);
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("aw_count", aw_cnt, NB);
    for (int i = 0; i < NB; i++)
      chk("awaddr", i < aw_addrs.size() ? aw_addrs[i] : 'x, BASE + AW'(i * BB));
    chk("beats", beats, FW);
    chk("fifo_drained", fifo_q.size(), 0);
    chk("b_count", b_cnt, NB);
    chk("err", err, exp_err);
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    exp_aw_next = 0; exp_done_next = 0; prev_awv = 0;
    b_owed = 0;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    int n;
    logic [1:0] b0, b1;
    rst = 1'b1; start = 1'b0; fifo_rd_vld = 1'b0; fifo_rd_data = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    gap_at = 0; gap_left = 0;
    bresp_plan[0] = 2'b00; bresp_plan[1] = 2'b00;
    knobs(100, 100, 100, 100, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_wvalid", m_wvalid, 1'b0);
    chk("rst_wlast", m_wlast, 1'b0);
    chk("rst_bready", m_bready, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_awaddr", m_awaddr, BASE);
    chk("awlen", m_awlen, BL - 1);
    chk("wstrb", m_wstrb, {(DW/8){1'b1}});
    rst = 1'b0;
    step();
    // all ready, FIFO full
    begin_frame(2'b00, 2'b00);
    end_frame(1'b0);
    // FIFO runs dry for 5 cycles after beat 1
    gap_at = 2; gap_left = 5;
    begin_frame(2'b00, 2'b00);
    end_frame(1'b0);
    chk("gap_used", gap_left, 0);
    // slow AW acceptance and alternating W ready
    knobs(30, 100, 100, 100, 1);
    begin_frame(2'b00, 2'b00);
    end_frame(1'b0);
    // SLVERR on first burst is sticky until the next start
    knobs(100, 100, 100, 100, 0);
    begin_frame(2'b10, 2'b00);
    end_frame(1'b1);
    repeat (3) step();
    chk("err_sticky", err, 1'b1);
    // reset in the middle of the W phase
    begin_frame(2'b00, 2'b00);
    n = 0;
    while (beats < 2 && n < 50) begin
      step();
      n++;
    end
    chk("reached_beat2", beats, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_awvalid", m_awvalid, 1'b0);
    chk("mid_rst_wvalid", m_wvalid, 1'b0);
    chk("mid_rst_wlast", m_wlast, 1'b0);
    chk("mid_rst_bready", m_bready, 1'b0);
    chk("mid_rst_rd_en", fifo_rd_en, 1'b0);
    chk("mid_rst_awaddr", m_awaddr, BASE);
    apply_reset();
    repeat (3) step();
    chk("no_done_after_rst", done_cnt, 0);
    begin_frame(2'b00, 2'b00);
    end_frame(1'b0);
    // randomized handshakes and responses
    repeat (15) begin
      knobs($urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(40, 100),
            $urandom_range(40, 100), 0);
      b0 = ($urandom() % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b1 = ($urandom() % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      begin_frame(b0, b1);
      end_frame((b0 != 2'b00) || (b1 != 2'b00));
    end
    // W channel never ready
    knobs(100, 0, 100, 100, 0);
    begin_frame(2'b00, 2'b00);
    n = 0;
    while (done_cnt == 0 && n < 40) begin
      step();
      n++;
    end
`ifdef DDR_WR_TIMEOUT_EN
    chk("tmo_done", done_cnt > 0, 1'b1);
    chk("tmo_not_early", n >= TO, 1'b1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
`else
    chk("stall_no_done", done_cnt, 0);
    chk("stall_busy", busy, 1'b1);
    chk("stall_err", err, 1'b0);
`endif
    knobs(100, 100, 100, 100, 0);
    apply_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
